pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset reset, asynchronous, active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 ifid_rs1, ifid_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 idex_mem_read  input  1  instruction in EX is a load.
REQ-006 idex_rd  input  5  destination register of the instruction in EX.
REQ-007 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-008 exmem_mem_read, exmem_mem_write  input  1 each  registered outputs of the EX/MEM stage register.
REQ-009 dmem_ack  input  1  data memory completes the current access this cycle.
REQ-010 dmem_req  output  1  data memory access request.
REQ-011 pc_en, ifid_en, idex_en, exmem_en  output  1 each  stage-register load enables, 1 = advance.
REQ-012 ifid_flush, idex_flush, exmem_flush  output  1 each  insert a bubble (control bits cleared) on the next edge.
REQ-013 stall_count  output  16  saturating count of cycles with pc_en=0.

Function
REQ-014 The FSM SHALL have exactly two states: RUN and MEM_WAIT; reset state RUN.
REQ-015 mem_op = exmem_mem_read | exmem_mem_write.
REQ-016 dmem_req SHALL be 1 when (RUN & mem_op) or MEM_WAIT, else 0; it is combinational, zero latency.
REQ-017 RUN, mem_op=1, dmem_ack=0 -> next state MEM_WAIT; mem_op=1, dmem_ack=1 -> stay RUN, no stall.
REQ-018 MEM_WAIT, dmem_ack=0 -> stay; dmem_ack=1 -> RUN; dmem_req SHALL be held at 1 until ack, regardless of mem_op.
REQ-019 mem_stall = dmem_req & ~dmem_ack; when 1, all four enables = 0 and all flushes = 0 (full freeze, highest priority).
REQ-020 load_use = idex_mem_read & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2).
REQ-021 No mem_stall, branch_taken=1: all enables 1, ifid_flush=1, idex_flush=1, exmem_flush=0; load_use ignored.
REQ-022 No mem_stall, no branch, load_use=1: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1; single-cycle bubble.
REQ-023 Otherwise all enables 1, all flushes 0.
REQ-024 exmem_flush SHALL be 0 in every case (reserved); EX/MEM never bubbles under this controller.
REQ-025 stall_count increments by 1 on each edge where pc_en=0; saturates at 16'hFFFF, no wrap.
REQ-026 Back-to-back memory ops: after an ack the next mem_op in EX/MEM issues a fresh request in RUN without an idle cycle.

Reset
REQ-027 Reset SHALL force state=RUN and stall_count=0 asynchronously; outputs then follow REQ-016..023 from inputs.
REQ-028 Reset asserted in MEM_WAIT SHALL drop dmem_req in the same cycle unless mem_op=1; the pending access is abandoned.

Structure
REQ-029 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MEM_WAIT), REG_ZERO=5'd0 and STALL_CNT_W=16.
REQ-030 Load-use comparison SHALL be a combinational sub-module hazard_detect (inputs ifid_rs1/rs2, idex_mem_read, idex_rd; output load_use).
REQ-031 Only state and stall_count are registers; all other outputs are combinational.

Verification
REQ-032 Load x5 in EX, ID reads rs1=x5 -> one cycle pc_en=ifid_en=0, idex_flush=1, stall_count 0->1.
REQ-033 Load x0 in EX, ID reads rs1=x0 -> no stall, stall_count stays 0.
REQ-034 exmem_mem_read=1, dmem_ack low 3 cycles then high -> dmem_req high 4 cycles, all enables 0 for 3 cycles, state back to RUN.
REQ-035 branch_taken=1 with load_use=1 -> ifid_flush=idex_flush=1, pc_en=1; same with mem_stall=1 -> full freeze, no flush.
REQ-036 Reset pulsed in MEM_WAIT with mem_op=0 -> dmem_req=0 immediately, state RUN, stall_count=0.
REQ-037 Hold a stall 65540 cycles -> stall_count saturates at 65535.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / memory-wait controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    // Per-cycle stage-register control bundle.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_ADVANCE = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == STALL_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard check between the load in EX and the sources read in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    output logic       load_use
);

    logic w_rd_nonzero;
    logic w_src_match;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_rd_nonzero = (idex_rd != REG_ZERO);
    assign w_src_match  = (idex_rd == ifid_rs1) | (idex_rd == ifid_rs2);
    assign load_use     = idex_mem_read & w_rd_nonzero & w_src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: memory-wait FSM, load-use bubble, branch flush and a
// saturating count of fetch-stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ifid_rs1,
    input  logic [4:0]             ifid_rs2,
    input  logic                   idex_mem_read,
    input  logic [4:0]             idex_rd,
    input  logic                   branch_taken,
    input  logic                   exmem_mem_read,
    input  logic                   exmem_mem_write,
    input  logic                   dmem_ack,
    output logic                   dmem_req,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic [STALL_CNT_W-1:0] stall_count
);

    state_t                 r_state;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic      w_mem_op;
    logic      w_dmem_req;
    logic      w_mem_stall;
    logic      w_load_use;
    pipe_ctl_t w_ctl;

    hazard_detect u_hazard (
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .load_use      (w_load_use)
    );

    assign w_mem_op = exmem_mem_read | exmem_mem_write;

    // Once waiting, the request stays up until ack even if EX/MEM changes.
    assign w_dmem_req  = (r_state == MEM_WAIT) | ((r_state == RUN) & w_mem_op);
    assign w_mem_stall = w_dmem_req & ~dmem_ack;

    always_comb begin
        w_ctl = CTL_ADVANCE;
        if (w_mem_stall) begin
            w_ctl = '0;
        end else if (branch_taken) begin
            w_ctl.ifid_flush = 1'b1;
            w_ctl.idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_ctl.pc_en      = 1'b0;
            w_ctl.ifid_en    = 1'b0;
            w_ctl.idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:      if (w_mem_op && !dmem_ack) r_state <= MEM_WAIT;
                MEM_WAIT: if (dmem_ack)              r_state <= RUN;
                default:                             r_state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (!w_ctl.pc_en) begin
            r_stall_count <= sat_inc(r_stall_count);
        end
    end

    assign dmem_req    = w_dmem_req;
    assign pc_en       = w_ctl.pc_en;
    assign ifid_en     = w_ctl.ifid_en;
    assign idex_en     = w_ctl.idex_en;
    assign exmem_en    = w_ctl.exmem_en;
    assign ifid_flush  = w_ctl.ifid_flush;
    assign idex_flush  = w_ctl.idex_flush;
    assign exmem_flush = w_ctl.exmem_flush;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: stimulus pushes expectations,
// a monitor pops and compares one sample per checked cycle.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
    logic        idex_mem_read, branch_taken;
    logic        exmem_mem_read, exmem_mem_write, dmem_ack;
    logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [15:0] stall_count;

    pipe_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .ifid_rs1        (ifid_rs1),
        .ifid_rs2        (ifid_rs2),
        .idex_mem_read   (idex_mem_read),
        .idex_rd         (idex_rd),
        .branch_taken    (branch_taken),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .dmem_ack        (dmem_ack),
        .dmem_req        (dmem_req),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_flush, dmem_req}
    localparam logic [7:0] RUNN   = 8'b1111_000_0;
    localparam logic [7:0] REQ    = 8'b1111_000_1;
    localparam logic [7:0] FREEZE = 8'b0000_000_1;
    localparam logic [7:0] BUB    = 8'b0011_010_0;
    localparam logic [7:0] BRANCH = 8'b1111_110_0;

    logic [23:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    event        smp_ev;

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic ldr, input logic [4:0] rd, input logic br,
                         input logic mr, input logic mw, input logic ack);
        @(negedge clk);
        reset           = r;
        ifid_rs1        = rs1;
        ifid_rs2        = rs2;
        idex_mem_read   = ldr;
        idex_rd         = rd;
        branch_taken    = br;
        exmem_mem_read  = mr;
        exmem_mem_write = mw;
        dmem_ack        = ack;
    endtask

    task automatic chk(input logic [7:0] ectl, input logic [15:0] esc, input string nm);
        exp_q.push_back({ectl, esc});
        name_q.push_back(nm);
        -> smp_ev;
    endtask

    initial begin : monitor
        logic [23:0] e, act;
        string       n;
        forever begin
            @(smp_ev);
            #2;
            act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
                   exmem_flush, dmem_req, stall_count};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL monitor: sample with no expected entry, got %b", act);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (act !== e)
                    begin
                        bad++;
                        $display("FAIL %s: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d",
                                 n, act[23:16], act[15:0], e[23:16], e[15:0]);
                    end
            end
        end
    end

    initial begin : stim
        int guard;
        reset = 1'b1; ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
        idex_mem_read = 1'b0; branch_taken = 1'b0;
        exmem_mem_read = 1'b0; exmem_mem_write = 1'b0; dmem_ack = 1'b0;

        //     rst rs1 rs2 ldr rd br mr mw ack
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   0, "reset_idle");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   0, "idle");
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); chk(RUNN,   0, "load_x0_no_stall");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   0, "load_x0_count_same");
        drive(0, 5, 3, 1, 5, 0, 0, 0, 0); chk(BUB,    0, "load_use_rs1");
        drive(0, 5, 3, 0, 5, 0, 0, 0, 0); chk(RUNN,   1, "bubble_one_cycle");
        drive(0, 2, 7, 1, 7, 0, 0, 0, 0); chk(BUB,    1, "load_use_rs2");
        drive(0, 2, 7, 0, 7, 0, 0, 0, 0); chk(RUNN,   2, "match_not_load");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 2, "mem_wait_1");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 3, "mem_wait_2");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 4, "mem_wait_3");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1); chk(REQ,    5, "mem_ack");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   5, "back_in_run");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1); chk(REQ,    5, "store_ack_same_cycle");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1); chk(REQ,    5, "back_to_back_load");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); chk(FREEZE, 5, "store_wait");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(FREEZE, 6, "req_held_no_memop");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); chk(REQ,    7, "ack_in_wait_no_memop");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   7, "idle_after_wait");
        drive(0, 5, 0, 1, 5, 1, 0, 0, 0); chk(BRANCH, 7, "branch_over_load_use");
        drive(0, 5, 0, 1, 5, 1, 1, 0, 0); chk(FREEZE, 7, "branch_under_mem_stall");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); chk(REQ,    8, "ack_after_branch_freeze");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   8, "idle_2");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 8, "enter_wait");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   0, "reset_in_wait");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); chk(RUNN,   0, "after_reset_run");
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 0, "reset_with_memop");
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 0, "reset_holds_count");

        repeat (65534) drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 16'd65534, "count_near_max");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 16'hFFFF, "count_at_max");
        repeat (5) drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); chk(FREEZE, 16'hFFFF, "count_saturated");

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
